// File: rtl/riscv_constants.sv
// Shared types and constants for the RISC-V front end.
// The fetch buffer entry is sized for a 32-bit datapath.
package riscv_constants;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } if_entry_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_ifetch_if.sv
// Fetch-stage bus: imem request/response channel plus the decode-facing instruction channel.
// The master side is the fetch unit; the slave side is imem and decode together.
interface riscv_ifetch_if #(
  parameter int WORD_LENGTH = 32
);

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [WORD_LENGTH-1:0] imem_req_addr;
  logic                   imem_rsp_valid;
  logic [WORD_LENGTH-1:0] imem_rsp_data;

  logic                   inst_valid;
  logic                   inst_ready;
  logic [WORD_LENGTH-1:0] inst;
  logic [WORD_LENGTH-1:0] inst_pc;
  logic                   inst_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc, inst_misaligned,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc, inst_misaligned,
    output inst_ready
  );

endinterface

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, synchronous flush and occupancy count.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module riscv_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity,
  // so resetting the array would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: credit-limited in-order imem requests, response buffering with PC,
// redirect kill of in-flight fetches, and NOP injection for misaligned fetch addresses.
module riscv_ifetch
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH     = 32,
  parameter int BUF_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic [WORD_LENGTH-1:0] fetch_pc,
  input  logic                   redirect,
  output logic                   pc_advance,
  riscv_ifetch_if.master         bus
);

  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = $bits(if_entry_t);

  logic [OW-1:0]          outstanding;
  logic [OW-1:0]          outstanding_next;
  logic [OW-1:0]          drop_count;
  logic [OW-1:0]          drop_count_next;
  logic                   mis_done;

  logic                   aligned;
  logic                   credit;
  logic                   accept;
  logic                   deq;
  logic                   rsp_keep;
  logic                   mis_push;

  logic                   buf_push;
  logic                   buf_full;
  logic                   buf_empty;
  logic [BW-1:0]          buf_count;
  if_entry_t              buf_in;
  if_entry_t              buf_head;

  logic [WORD_LENGTH-1:0] pcq_head;
  logic                   pcq_full;
  logic                   pcq_empty;
  logic [OW-1:0]          pcq_count;

  assign aligned = !is_misaligned(fetch_pc[1:0]);
  assign deq     = bus.inst_valid && bus.inst_ready && !redirect;

  // The head leaving this cycle frees its slot for a response arriving next cycle,
  // which is what sustains one fetch per cycle with a two-entry buffer.
  assign credit = (int'(outstanding) + int'(buf_count) - int'(deq) < BUF_DEPTH)
               && (int'(outstanding) < MAX_OUTSTANDING);

  assign bus.imem_req_valid = credit && !redirect && aligned && !x_reset;
  assign bus.imem_req_addr  = fetch_pc;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_advance         = accept;

  // The first drop_count responses belong to fetches killed by a redirect.
  assign rsp_keep = bus.imem_rsp_valid && (drop_count == '0) && !redirect;

  // A misaligned PC yields exactly one NOP entry, after older fetches have drained,
  // and then waits for a redirect.
  assign mis_push = !aligned && !mis_done && (outstanding == '0) && (drop_count == '0)
                 && !buf_full && !redirect && !x_reset;

  assign buf_push = rsp_keep || mis_push;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    buf_in            = '0;
    buf_in.inst       = bus.imem_rsp_data;
    buf_in.pc         = pcq_head;
    buf_in.misaligned = 1'b0;
    if (mis_push) begin
      buf_in.inst       = NOP_INST;
      buf_in.pc         = fetch_pc;
      buf_in.misaligned = 1'b1;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    drop_count_next  = drop_count;
    if (redirect) begin
      // The response landing in the redirect cycle is itself stale and consumed here.
      outstanding_next = outstanding - OW'(bus.imem_rsp_valid);
      drop_count_next  = outstanding_next;
    end else begin
      outstanding_next = outstanding + OW'(accept) - OW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (drop_count != '0)) begin
        drop_count_next = drop_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      outstanding <= '0;
      drop_count  <= '0;
      mis_done    <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      drop_count  <= drop_count_next;
      if (redirect) begin
        mis_done <= 1'b0;
      end else if (mis_push) begin
        mis_done <= 1'b1;
      end
    end
  end

  riscv_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .rst       (x_reset),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (deq),
    .flush     (redirect),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  riscv_sync_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (x_reset),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .flush     (redirect),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  // Gating with inst_valid keeps the outputs at zero while the buffer is empty or in reset.
  assign bus.inst_valid      = !buf_empty;
  assign bus.inst            = bus.inst_valid ? buf_head.inst : '0;
  assign bus.inst_pc         = bus.inst_valid ? buf_head.pc : '0;
  assign bus.inst_misaligned = bus.inst_valid && buf_head.misaligned;

  pcq_underflow: assert property (@(posedge clk) disable iff (x_reset)
    !(rsp_keep && pcq_empty));
  pcq_overflow: assert property (@(posedge clk) disable iff (x_reset)
    !(accept && pcq_full));
  pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (x_reset)
    pcq_count <= outstanding);

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: a fixed-latency in-order imem model and a PC register
// model surround the DUT; each scenario task checks hand-computed cycle-by-cycle values.
module tb_riscv_ifetch;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        x_reset = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic        redirect = 1'b0;
  logic        pc_advance;

  logic [31:0] pc_init = 32'h0;
  logic [31:0] redirect_target = 32'h0;
  int          lat = 1;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  riscv_ifetch_if #(.WORD_LENGTH(32)) bus ();

  riscv_ifetch #(
    .WORD_LENGTH     (32),
    .BUF_DEPTH       (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk        (clk),
    .x_reset    (x_reset),
    .fetch_pc   (fetch_pc),
    .redirect   (redirect),
    .pc_advance (pc_advance),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hC0DE_0000 | {16'h0, addr[15:0]};
  endfunction

  // imem and PC models: sample mid-cycle, update just after the rising edge.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  logic  adv_s = 1'b0;
  logic  redir_s = 1'b0;

  always @(negedge clk) begin
    adv_s   = pc_advance;
    redir_s = redirect;
    if (x_reset) begin
      pend.delete();
    end else begin
      if (bus.imem_rsp_valid === 1'b1) void'(pend.pop_front());
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1)
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (x_reset)      fetch_pc = pc_init;
    else if (redir_s) fetch_pc = redirect_target;
    else if (adv_s)   fetch_pc = fetch_pc + 32'd4;
    if (!x_reset && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench at the drive point of cycle 0, the first cycle out of reset.
  task automatic do_reset(input logic [31:0] pc, input int l, input logic rdy);
    next_cycle();
    x_reset            = 1'b1;
    redirect           = 1'b0;
    pc_init            = pc;
    lat                = l;
    bus.inst_ready     = rdy;
    bus.imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    x_reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
    end
    tests_run++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_misaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got inst=%h pc=%h mis=%b want 0/0/0",
               bus.inst, bus.inst_pc, bus.inst_misaligned);
    end
    tests_run++;
    if (bus.imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req: got req_valid=%b pc_advance=%b want 0/0",
               bus.imem_req_valid, pc_advance);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    do_reset(32'h0, 1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests_run++;
      if (pc_advance !== 1'b1) begin
        tests_failed++; $display("FAIL stream_advance c%0d: got %b want 1", k, pc_advance);
      end
      tests_run++;
      if (k < 2) begin
        if (bus.inst_valid !== 1'b0) begin
          tests_failed++; $display("FAIL stream_early c%0d: got valid=%b want 0", k, bus.inst_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL stream_inst c%0d: got valid=%b pc=%h inst=%h want 1/%h/%h",
                   k, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc, mem_word(exp_pc));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_pc;
    do_reset(32'h200, 1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k == 5) bus.inst_ready = 1'b1;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        tests_run++;
        if (bus.imem_req_valid !== 1'b0) begin
          tests_failed++; $display("FAIL bp_credit c%0d: got req_valid=%b want 0", k, bus.imem_req_valid);
        end
      end
      if (k == 4) begin
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200) begin
          tests_failed++;
          $display("FAIL bp_hold: got valid=%b pc=%h want 1/00000200", bus.inst_valid, bus.inst_pc);
        end
      end
      if (k == 5) begin
        tests_run++;
        if (pc_advance !== 1'b1 || bus.imem_req_addr !== 32'h208) begin
          tests_failed++;
          $display("FAIL bp_resume: got adv=%b addr=%h want 1/00000208", pc_advance, bus.imem_req_addr);
        end
      end
      if (k >= 5) begin
        exp_pc = 32'h200 + 32'(4 * (k - 5));
        tests_run++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL bp_order c%0d: got valid=%b pc=%h inst=%h want 1/%h/%h",
                   k, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc, mem_word(exp_pc));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_stale;
    do_reset(32'h0, 3, 1'b1);
    next_cycle();
    next_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h100;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_redirect_req: got req_valid=%b adv=%b want 0/0", bus.imem_req_valid, pc_advance);
    end
    next_cycle();
    redirect = 1'b0;
    for (int k = 3; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        tests_run++;
        if (pc_advance !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
          tests_failed++;
          $display("FAIL stale_first_req: got adv=%b addr=%h want 1/00000100", pc_advance, bus.imem_req_addr);
        end
      end
      tests_run++;
      if (k < 8) begin
        if (bus.inst_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stale_leak c%0d: got valid=%b pc=%h want no instruction", k, bus.inst_valid, bus.inst_pc);
        end
      end else begin
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 + 32'(4 * (k - 8))
            || bus.inst !== mem_word(32'h100 + 32'(4 * (k - 8)))) begin
          tests_failed++;
          $display("FAIL stale_target c%0d: got valid=%b pc=%h inst=%h want 1/%h",
                   k, bus.inst_valid, bus.inst_pc, bus.inst, 32'h100 + 32'(4 * (k - 8)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_with_rsp;
    do_reset(32'h40, 2, 1'b1);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    next_cycle();
    redirect           = 1'b1;
    redirect_target    = 32'h300;
    bus.imem_req_ready = 1'b1;
    lat                = 1;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rsp_redirect_req: got req_valid=%b want 0", bus.imem_req_valid);
    end
    next_cycle();
    redirect = 1'b0;
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        tests_run++;
        if (pc_advance !== 1'b1 || bus.imem_req_addr !== 32'h300) begin
          tests_failed++;
          $display("FAIL rsp_first_req: got adv=%b addr=%h want 1/00000300", pc_advance, bus.imem_req_addr);
        end
      end
      tests_run++;
      if (k < 5) begin
        if (bus.inst_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL rsp_leak c%0d: got valid=%b pc=%h want no instruction", k, bus.inst_valid, bus.inst_pc);
        end
      end else begin
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h300 + 32'(4 * (k - 5))
            || bus.inst !== mem_word(32'h300 + 32'(4 * (k - 5)))) begin
          tests_failed++;
          $display("FAIL rsp_deliver c%0d: got valid=%b pc=%h inst=%h want 1/%h",
                   k, bus.inst_valid, bus.inst_pc, bus.inst, 32'h300 + 32'(4 * (k - 5)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_misaligned;
    do_reset(32'h102, 1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (bus.imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_no_req: got req_valid=%b adv=%b want 0/0", bus.imem_req_valid, pc_advance);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== NOP_INST || bus.inst_misaligned !== 1'b1
        || bus.inst_pc !== 32'h102) begin
      tests_failed++;
      $display("FAIL mis_entry: got valid=%b inst=%h mis=%b pc=%h want 1/00000013/1/00000102",
               bus.inst_valid, bus.inst, bus.inst_misaligned, bus.inst_pc);
    end
    next_cycle();
    next_cycle();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (pc_advance !== 1'b0 || bus.inst_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mis_hold: got adv=%b valid=%b want 0/1", pc_advance, bus.inst_valid);
    end
    next_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h800;
    @(negedge clk);
    tests_run++;
    if (bus.inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mis_single: got valid=%b want 0 (one entry only)", bus.inst_valid);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pc_advance !== 1'b1 || bus.imem_req_addr !== 32'h800) begin
      tests_failed++;
      $display("FAIL mis_recover: got adv=%b addr=%h want 1/00000800", pc_advance, bus.imem_req_addr);
    end
  endtask

  task automatic test_reset_pulse;
    do_reset(32'h600, 1, 1'b0);
    repeat (4) next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h600) begin
      tests_failed++;
      $display("FAIL pulse_setup: got valid=%b pc=%h want 1/00000600", bus.inst_valid, bus.inst_pc);
    end
    next_cycle();
    x_reset = 1'b1;
    #1;
    tests_run++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0
        || bus.imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_async: got valid=%b inst=%h pc=%h req=%b want 0/0/0/0",
               bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_valid);
    end
    do_reset(32'h700, 1, 1'b1);
    @(negedge clk);
    tests_run++;
    if (pc_advance !== 1'b1 || bus.imem_req_addr !== 32'h700) begin
      tests_failed++;
      $display("FAIL pulse_restart: got adv=%b addr=%h want 1/00000700", pc_advance, bus.imem_req_addr);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h700 || bus.inst !== mem_word(32'h700)) begin
      tests_failed++;
      $display("FAIL pulse_first_inst: got valid=%b pc=%h inst=%h want 1/00000700/%h",
               bus.inst_valid, bus.inst_pc, bus.inst, mem_word(32'h700));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_with_rsp();
    test_misaligned();
    test_reset_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
